// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a big-endian byte-lane data RAM.
// Define LLSC_EN to add the LL/SC reservation bit; without it SC behaves as SW returning 1.
module mem_access_unit #(
  parameter int unsigned ACCESS_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  input  logic [31:0] ram_data_i,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_data,
  output logic        stall_req,
  output logic [31:0] wdata_o,
  output logic        wdata_valid,
  output logic        misalign_exc
);
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] result_q, result_d;

  logic        op_known, is_byte, is_half, is_word, misaligned, accept, sc_fail;
  logic [3:0]  req_sel;
  logic [31:0] req_sdata;

  function automatic logic is_store_op(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SC};
  endfunction

  // Lane 0 of the address is the most significant byte of the word.
  function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = a[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LB:        return {{24{b[7]}}, b};
      OP_LBU:       return {24'd0, b};
      OP_LH:        return {{16{h[15]}}, h};
      OP_LHU:       return {16'd0, h};
      OP_LW, OP_LL: return w;
      OP_SC:        return 32'd1;
      default:      return 32'd0;
    endcase
  endfunction

  always_comb begin
    op_known   = mem_op inside {[OP_LB:OP_SC]};
    is_byte    = mem_op inside {OP_LB, OP_LBU, OP_SB};
    is_half    = mem_op inside {OP_LH, OP_LHU, OP_SH};
    is_word    = op_known && !is_byte && !is_half;
    misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
    req_sel    = 4'b1111;
    req_sdata  = store_data;
    if (is_byte) begin
      req_sel   = 4'b1000 >> mem_addr[1:0];
      req_sdata = {4{store_data[7:0]}};
    end else if (is_half) begin
      req_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
      req_sdata = {2{store_data[15:0]}};
    end
    accept = (state_q == S_IDLE) && req_valid && op_known && !misaligned && !flush;
  end

`ifdef LLSC_EN
  logic llbit_q, llbit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) llbit_q <= 1'b0;
    else     llbit_q <= llbit_d;
  end

  always_comb begin
    llbit_d = llbit_q;
    if (flush) begin
      llbit_d = 1'b0;
    end else if (state_q == S_DONE) begin
      if (op_q == OP_LL)      llbit_d = 1'b1;
      else if (op_q == OP_SC) llbit_d = 1'b0;
    end
  end

  // A failed SC never touches the RAM and reports 0.
  assign sc_fail = (mem_op == OP_SC) && !llbit_q;
`else
  assign sc_fail = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 4'd0;
      addr_q   <= 32'd0;
      sel_q    <= 4'd0;
      sdata_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      sdata_q  <= sdata_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    sdata_d  = sdata_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = mem_op;
          addr_d   = mem_addr;
          sel_d    = req_sel;
          sdata_d  = req_sdata;
          cnt_d    = CNT_INIT;
          result_d = 32'd0;
          state_d  = sc_fail ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = S_DONE;
          result_d = load_result(op_q, addr_q[1:0], ram_data_i);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_ce       = (state_q == S_ACCESS) && !flush;
    ram_we       = ram_ce && is_store_op(op_q);
    ram_addr     = ram_ce ? {addr_q[31:2], 2'b00} : 32'd0;
    ram_sel      = ram_ce ? sel_q : 4'd0;
    ram_data     = ram_we ? sdata_q : 32'd0;
    stall_req    = (state_q == S_ACCESS) || accept;
    wdata_valid  = (state_q == S_DONE) && !flush;
    wdata_o      = wdata_valid ? result_q : 32'd0;
    misalign_exc = (state_q == S_IDLE) && req_valid && op_known && misaligned && !flush;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level model plus per-cycle compare.
// Built with or without LLSC_EN; the model follows the same macro.
module tb_mem_access_unit;
  localparam int LAT = 3;
`ifdef LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif
  localparam logic [3:0] LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
  localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8, LL = 4'd9, SC = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] ram_data_i;
  logic        ram_ce, ram_we, stall_req, wdata_valid, misalign_exc;
  logic [31:0] ram_addr, ram_data, wdata_o;
  logic [3:0]  ram_sel;

  mem_access_unit #(.ACCESS_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op), .mem_addr(mem_addr),
    .store_data(store_data), .flush(flush), .ram_data_i(ram_data_i), .ram_ce(ram_ce),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_data(ram_data),
    .stall_req(stall_req), .wdata_o(wdata_o), .wdata_valid(wdata_valid),
    .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  // RAM seen by the DUT, and the reference memory the model keeps.
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int we_run;
  assign ram_data_i = mem[ram_addr[7:2]];

  // The RAM commits only after write-enable has been held for the whole access.
  always @(posedge clk or posedge rst) begin
    if (rst) we_run = 0;
    else if (ram_ce && ram_we) begin
      if (we_run == LAT - 1) begin
        for (int l = 0; l < 4; l++)
          if (ram_sel[l]) mem[ram_addr[7:2]][8*l +: 8] = ram_data[8*l +: 8];
        we_run = 0;
      end else we_run++;
    end else we_run = 0;
  end

  int n_checks = 0, n_errors = 0;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  bit          chk_en = 1'b0;
  bit          e_stall, e_ce, e_we, e_wv, e_mis;
  logic [31:0] e_addr, e_data, e_wdata;
  logic [3:0]  e_sel;
  int          stall_cnt, we_cnt, ce_cnt, mis_cnt, wv_cnt;
  logic [3:0]  last_sel;
  logic [31:0] last_data, last_wdata;
  bit          llbit = 1'b0;

  always @(negedge clk) if (chk_en) begin
    chk("stall_req", 32'(stall_req), 32'(e_stall));
    chk("ram_ce", 32'(ram_ce), 32'(e_ce));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("wdata_valid", 32'(wdata_valid), 32'(e_wv));
    chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
    if (e_ce) begin
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_sel", 32'(ram_sel), 32'(e_sel));
    end
    if (e_we) chk("ram_data", ram_data, e_data);
    if (e_wv) chk("wdata_o", wdata_o, e_wdata);
    if (stall_req) stall_cnt++;
    if (ram_ce) begin ce_cnt++; last_sel = ram_sel; end
    if (ram_we) begin we_cnt++; last_data = ram_data; end
    if (misalign_exc) mis_cnt++;
    if (wdata_valid) begin wv_cnt++; last_wdata = wdata_o; end
  end

  function automatic bit known(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd10;
  endfunction
  function automatic bit is_st(input logic [3:0] op);
    return op == SB || op == SH || op == SW || op == SC;
  endfunction
  function automatic int size_of(input logic [3:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_result(input logic [3:0] op, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          n;
    w = ref_mem[a[7:2]];
    n = int'(a[1:0]);
    b = 8'(w >> (8 * (3 - n)));
    h = 16'(w >> (16 * (1 - n / 2)));
    case (op)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'd0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'd0, h};
      LW, LL:  return w;
      SC:      return (LLSC && !llbit) ? 32'd0 : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] a);
    if (size_of(op) == 1) return 4'(1 << (3 - int'(a[1:0])));
    if (size_of(op) == 2) return a[1] ? 4'h3 : 4'hC;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_rep(input logic [3:0] op, input logic [31:0] d);
    if (size_of(op) == 1) return {4{d[7:0]}};
    if (size_of(op) == 2) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic clr_exp();
    {e_stall, e_ce, e_we, e_wv, e_mis} = 5'd0;
    e_addr = 32'd0; e_data = 32'd0; e_wdata = 32'd0; e_sel = 4'd0;
  endtask

  task automatic clr_caps();
    stall_cnt = 0; we_cnt = 0; ce_cnt = 0; mis_cnt = 0; wv_cnt = 0;
    last_sel = 4'd0; last_data = 32'd0; last_wdata = 32'hDEAD_0000;
  endtask

  task automatic idle_cycle(input bit fl);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_op = 4'd0; flush = fl;
    clr_exp();
    if (fl) llbit = 1'b0;
  endtask

  // Issue one request; flush_k is the cycle (0 = issue cycle) on which flush is raised, -1 none.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input int flush_k);
    bit mis, acc, skip, st, aborted;
    int n_acc;
    logic [31:0] res, rep;
    logic [3:0] sel;
    mis = known(op) && ((size_of(op) == 2 && addr[0]) || (size_of(op) == 4 && addr[1:0] != 2'b00));
    acc = known(op) && !mis && flush_k != 0;
    skip = LLSC && op == SC && !llbit;
    st = is_st(op);
    n_acc = skip ? 0 : LAT;
    sel = exp_sel(op, addr);
    rep = exp_rep(op, sd);
    res = exp_result(op, addr);
    aborted = !acc;
    for (int k = 0; k <= n_acc + 1; k++) begin
      @(posedge clk); #1;
      req_valid = (k == 0); mem_op = (k == 0) ? op : 4'd0;
      mem_addr = addr; store_data = sd; flush = (k == flush_k);
      clr_exp();
      if (k == 0) begin
        e_stall = acc;
        e_mis = mis && flush_k != 0;
      end else if (!aborted && k <= n_acc) begin
        e_stall = 1'b1;
        if (k == flush_k) aborted = 1'b1;
        else begin
          e_ce = 1'b1; e_we = st; e_addr = {addr[31:2], 2'b00}; e_sel = sel; e_data = rep;
        end
      end else if (!aborted && k == n_acc + 1) begin
        if (k == flush_k) aborted = 1'b1;
        else begin
          e_wv = 1'b1; e_wdata = res;
          if (st && !skip)
            for (int l = 0; l < 4; l++)
              if (sel[l]) ref_mem[addr[7:2]][8*l +: 8] = rep[8*l +: 8];
          if (LLSC && op == LL) llbit = 1'b1;
          if (LLSC && op == SC) llbit = 1'b0;
        end
      end
      if (flush) llbit = 1'b0;
    end
    idle_cycle(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{8'(i)}};
    mem[4] = 32'h1122_3380;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    clr_exp(); clr_caps();

    #1 rst = 1'b1;
    #3;
    chk("rst_ram_ce", 32'(ram_ce), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_sel", 32'(ram_sel), 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_wdata_o", wdata_o, 32'd0);
    chk("rst_wdata_valid", 32'(wdata_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_exc), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;

    clr_caps(); do_op(LB, 32'h13, 32'd0, -1);
    chk("lb_wdata", last_wdata, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lb_sel", 32'(last_sel), 32'h1);
    clr_caps(); do_op(LBU, 32'h13, 32'd0, -1);
    chk("lbu_wdata", last_wdata, 32'h0000_0080);

    clr_caps(); do_op(SH, 32'h22, 32'h0000_BEEF, -1);
    chk("sh_sel", 32'(last_sel), 32'h3);
    chk("sh_data", last_data, 32'hBEEF_BEEF);
    chk("sh_we_cycles", 32'(we_cnt), 32'd3);
    clr_caps(); do_op(LW, 32'h20, 32'd0, -1);
    chk("sh_merge", last_wdata, 32'h0808_BEEF);

    clr_caps(); do_op(LW, 32'h06, 32'd0, -1);
    chk("mis_pulses", 32'(mis_cnt), 32'd1);
    chk("mis_ce", 32'(ce_cnt), 32'd0);
    chk("mis_stall", 32'(stall_cnt), 32'd0);
    chk("mis_wv", 32'(wv_cnt), 32'd0);

    do_op(LH, 32'h12, 32'd0, -1);
    do_op(LH, 32'h10, 32'd0, -1);
    do_op(LHU, 32'h12, 32'd0, -1);
    do_op(LB, 32'h10, 32'd0, -1);
    do_op(LB, 32'h11, 32'd0, -1);
    do_op(LBU, 32'h12, 32'd0, -1);
    do_op(SB, 32'h31, 32'h1234_56A7, -1);
    clr_caps(); do_op(LW, 32'h30, 32'd0, -1);
    chk("sb_merge", last_wdata, 32'h0CA7_0C0C);
    do_op(SW, 32'h44, 32'h89AB_CDEF, -1);
    clr_caps(); do_op(LH, 32'h46, 32'd0, -1);
    chk("lh_neg", last_wdata, 32'hFFFF_CDEF);
    do_op(LHU, 32'h46, 32'd0, -1);
    do_op(SH, 32'h11, 32'h0000_1111, -1);
    do_op(SW, 32'h4A, 32'h0, -1);
    do_op(4'd12, 32'h40, 32'h0, -1);
    do_op(4'd0, 32'h40, 32'h0, -1);

    do_op(LL, 32'h40, 32'd0, -1);
    clr_caps(); do_op(SC, 32'h40, 32'h5555_0001, -1);
    chk("sc1_wdata", last_wdata, 32'd1);
    chk("sc1_we_cycles", 32'(we_cnt), 32'd3);
    clr_caps(); do_op(SC, 32'h40, 32'h6666_0002, -1);
`ifdef LLSC_EN
    chk("sc2_wdata", last_wdata, 32'd0);
    chk("sc2_ce", 32'(ce_cnt), 32'd0);
`else
    chk("sc2_wdata", last_wdata, 32'd1);
    chk("sc2_ce", 32'(ce_cnt), 32'd3);
`endif
    do_op(LL, 32'h40, 32'd0, -1);
    idle_cycle(1'b1);
    clr_caps(); do_op(SC, 32'h40, 32'h7777_0003, -1);
`ifdef LLSC_EN
    chk("sc3_wdata", last_wdata, 32'd0);
`else
    chk("sc3_wdata", last_wdata, 32'd1);
`endif
    do_op(LW, 32'h40, 32'd0, -1);

    clr_caps(); do_op(SW, 32'h50, 32'hCAFE_F00D, LAT);
    chk("flush_we_cycles", 32'(we_cnt), 32'd2);
    chk("flush_wv", 32'(wv_cnt), 32'd0);
    clr_caps(); do_op(LW, 32'h50, 32'd0, -1);
    chk("flush_no_write", last_wdata, 32'h1414_1414);
    clr_caps(); do_op(LW, 32'h10, 32'd0, LAT + 1);
    chk("flush_done_wv", 32'(wv_cnt), 32'd0);
    clr_caps(); do_op(LW, 32'h10, 32'd0, 0);
    chk("flush_issue_ce", 32'(ce_cnt), 32'd0);
    do_op(LW, 32'h10, 32'd0, 1);

    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; mem_op = SW; mem_addr = 32'h30; store_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_op = 4'd0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ce", 32'(ram_ce), 32'd0);
    chk("rst_mid_we", 32'(ram_we), 32'd0);
    chk("rst_mid_stall", 32'(stall_req), 32'd0);
    chk("rst_mid_addr", ram_addr, 32'd0);
    chk("rst_mid_data", ram_data, 32'd0);
    llbit = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    clr_exp();
    chk_en = 1'b1;
    clr_caps(); do_op(LW, 32'h30, 32'd0, -1);
    chk("rst_no_write", last_wdata, 32'h0CA7_0C0C);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
